stencil_frame_ctrl: RTL
=======================

Name: stencil_frame_ctrl

Overview:
- Sequencing controller for one 3x3 stencil stage (gaussian or sobel) in dut_system.
- Paces reads from the stage's input FIFO and shifts of its line-buffer/window.
- Paces writes into the output FIFO and flags border pixels for zeroing.
- Flushes the window after the last input pixel so each frame yields exactly IMG_WIDTH*IMG_HEIGHT outputs, then restarts automatically for the next frame.

Parameters:
- IMG_WIDTH, 64, pixels per row (>=3)
- IMG_HEIGHT, 32, rows per frame (>=3)
- CNT_WIDTH, 16, width of pixel counters; must hold IMG_WIDTH*IMG_HEIGHT+IMG_WIDTH+2

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- in_empty  in  1  input FIFO empty (first-word-fall-through; data valid while low)
- in_rd_en  out  1  pop input FIFO
- shift_en  out  1  advance line buffer/window by one pixel this cycle
- flush_sel  out  1  window shifts in 0 instead of FIFO data
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push datapath result into output FIFO
- border_zero  out  1  datapath must write 0 instead of the stencil result
- out_row  out  CNT_WIDTH  row of the pixel being written
- out_col  out  CNT_WIDTH  column of the pixel being written
- frame_done  out  1  one-cycle pulse after the last output of a frame
- busy  out  1  high while in_count>0 or state != FILL

Behaviour:
- Datapath contract: window registers update on rising edge when shift_en=1. The stencil result is combinational from the window contents before that shift.
- Define N=IMG_WIDTH*IMG_HEIGHT and P=IMG_WIDTH+2.
- The write issued at step k (k = shifts done so far, before this shift) is centred on input pixel k-P.
- Counters:
  - in_count: pixels popped, 0..N
  - step_count: shifts, 0..N+P
  - out_count: writes, 0..N
  - out_row, out_col: track out_count; out_col wraps IMG_WIDTH-1 -> 0 and increments out_row
- States: FILL, RUN, FLUSH, DONE. Reset -> FILL, all counters 0, frame_done=0.
- FILL:
  - step when in_empty=0; out_full is ignored.
  - in_rd_en=shift_en=1, out_wr_en=0.
  - After the step that makes step_count=P -> RUN.
- RUN:
  - step when in_empty=0 AND out_full=0.
  - in_rd_en=shift_en=out_wr_en=1.
  - After the step that makes in_count=N -> FLUSH.
- FLUSH:
  - step when out_full=0.
  - shift_en=out_wr_en=flush_sel=1, in_rd_en=0.
  - After the step that makes out_count=N -> DONE.
- DONE:
  - lasts one cycle; no step, frame_done=1.
  - Clears all counters, then -> FILL.
- No step in a cycle: in_rd_en, shift_en and out_wr_en are all 0, and counters hold.
- border_zero = out_wr_en AND (out_row==0 OR out_row==IMG_HEIGHT-1 OR out_col==0 OR out_col==IMG_WIDTH-1).
- Simultaneous in_empty=1 and out_full=1 in RUN: stall; both FIFOs stay untouched.
- out_full=1 in FILL does not stall.
- in_empty is ignored in FLUSH and DONE.
- Output timing: in_rd_en, shift_en, out_wr_en, flush_sel and border_zero are combinational from state, counters and FIFO flags. They are forced to 0 while reset=1.
- frame_done is registered.
- Reset mid-frame: next cycle state=FILL, counters 0, no partial flush. Any data left in the window is discarded by the next FILL.
- Throughput: one step per cycle when unstalled. A frame takes N+P+1 cycles minimum.
- Overflow: in_rd_en is never asserted with in_empty=1, and out_wr_en is never asserted with out_full=1.

Test Plan:
- Basic frame, IMG_WIDTH=4, IMG_HEIGHT=3, input never empty, output never full:
  - in_rd_en high for exactly 12 cycles; the first 6 have out_wr_en=0.
  - out_wr_en high for exactly 12 cycles; the last 6 have flush_sel=1.
  - frame_done pulses at cycle 19 after reset release; busy=0 after it.
- Border map, same 4x3 frame: border_zero=0 only on writes 5 and 6 (row1, col1/col2), 1 on the other 10 writes.
  - Write 5 occurs in RUN; write 6 is the first FLUSH write.
- Input starvation: in_empty toggled 1-0 every cycle.
  - Pops happen only on in_empty=0 cycles.
  - Output sequence and border flags are identical to the basic frame; completes in ~30 cycles.
- Backpressure: out_full held 1 for 5 cycles mid-RUN and 5 mid-FLUSH.
  - No in_rd_en or out_wr_en during either hold.
  - No writes lost or duplicated: exactly 12 writes total.
- Reset mid-operation: assert reset for 1 cycle after 8 pops.
  - All strobes 0 during reset; next frame starts in FILL with out_row=out_col=0.
  - Full 12 pops after release produce 12 writes.
- Back-to-back frames: 24 pixels preloaded.
  - Two frame_done pulses 19 cycles apart.
  - Second frame's first write occurs on the 7th pop after the first frame_done.

Source files
------------

// File: rtl/stencil_frame_ctrl.sv
// Sequencing controller for one 3x3 stencil stage: paces FIFO pops, window shifts,
// result pushes and border zeroing, then flushes the window at the end of each frame.
module stencil_frame_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic                 shift_en,
  output logic                 flush_sel,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic                 border_zero,
  output logic [CNT_WIDTH-1:0] out_row,
  output logic [CNT_WIDTH-1:0] out_col,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] N_PIX    = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] P_LAT    = CNT_WIDTH'(IMG_WIDTH + 2);
  localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH, DONE} state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] in_count, step_count, out_count;
  logic                 step, pop, push, flushing;

  function automatic logic is_border(input logic [CNT_WIDTH-1:0] row,
                                     input logic [CNT_WIDTH-1:0] col);
    return (row == '0) || (row == LAST_ROW) || (col == '0) || (col == LAST_COL);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (step && step_count == P_LAT - ONE) next_state = RUN;
      RUN:     if (step && in_count == N_PIX - ONE)   next_state = FLUSH;
      FLUSH:   if (step && out_count == N_PIX - ONE)  next_state = DONE;
      default: next_state = FILL;
    endcase
  end

  // FILL ignores the output FIFO; FLUSH ignores the input FIFO.
  always_comb begin
    step     = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    flushing = 1'b0;
    case (state)
      FILL: begin
        step = !in_empty;
        pop  = step;
      end
      RUN: begin
        step = !in_empty && !out_full;
        pop  = step;
        push = step;
      end
      FLUSH: begin
        step     = !out_full;
        push     = step;
        flushing = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_rd_en    = pop && !reset;
  assign shift_en    = step && !reset;
  assign out_wr_en   = push && !reset;
  assign flush_sel   = flushing && !reset;
  assign border_zero = out_wr_en && is_border(out_row, out_col);
  assign busy        = (in_count != '0) || (state != FILL);

  always_ff @(posedge clock) begin
    if (reset || state == DONE) begin
      in_count   <= '0;
      step_count <= '0;
      out_count  <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (step) begin
      step_count <= step_count + ONE;
      if (pop) in_count <= in_count + ONE;
      if (push) begin
        out_count <= out_count + ONE;
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + ONE;
        end else begin
          out_col <= out_col + ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= (next_state == DONE) && (state != DONE);
  end

endmodule
